// File: rtl/alu_logic_arbiter.sv
// ---------------------------------------------------------------------------
// alu_logic_arbiter
//   Shares one logic/shift/count unit among REQ requesters (execute stage,
//   address-generation helper, debug probe). A round-robin arbiter picks one
//   valid requester per cycle. Its operation is computed combinationally and
//   captured in a single registered result stage that supports backpressure.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   req_valid[REQ]   requester i has an operation pending
//   req_ready[REQ]   requester i is accepted this cycle (combinational)
//   req_a/req_b      per-requester operands, N bits
//   req_funct        per-requester selector::alu_function
//   req_sa           per-requester shift amount, $clog2(N) bits
//   rsp_valid        result register holds a result
//   rsp_ready        consumer takes the result this cycle
//   rsp_id           requester index that issued the held result
//   rsp_y            result value (zero for unsupported functions)
//   rsp_err          function was not a supported logic function
// ---------------------------------------------------------------------------
package selector;
    typedef enum logic [3:0] {
        AND                    = 4'd0,
        OR                     = 4'd1,
        XOR                    = 4'd2,
        NOR                    = 4'd3,
        SHIFT_LEFT             = 4'd4,
        SHIFT_LOGIC_RIGHT      = 4'd5,
        SHIFT_ARITHMATIC_RIGHT = 4'd6,
        ROTATE_RIGHT           = 4'd7,
        CLZ                    = 4'd8,
        CLO                    = 4'd9,
        ADD                    = 4'd10,   // arithmetic encodings: not handled here
        SUB                    = 4'd11
    } alu_function;
endpackage

module alu_logic_arbiter #(
    parameter  int N   = 32,
    parameter  int REQ = 2,
    localparam int SW  = $clog2(N),
    localparam int IW  = (REQ > 1) ? $clog2(REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQ-1:0]        req_valid,
    output logic [REQ-1:0]        req_ready,
    input  logic [N-1:0]          req_a     [REQ],
    input  logic [N-1:0]          req_b     [REQ],
    input  selector::alu_function req_funct [REQ],
    input  logic [SW-1:0]         req_sa    [REQ],
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic [N-1:0]          rsp_y,
    output logic                  rsp_err
);

    localparam int CW  = $clog2(N + 1);   // count result must be able to hold N
    localparam int IW1 = IW + 1;          // one spare bit for modulo wrap

    logic [IW-1:0]        rr_ptr_r;
    logic [IW-1:0]        rr_nxt_s;
    logic [IW-1:0]        gnt_id_s;
    logic                 gnt_any_s;
    logic                 can_accept_s;
    logic                 accept_s;
    logic [N-1:0]         op_a_s;
    logic [N-1:0]         op_b_s;
    logic [SW-1:0]        op_sa_s;
    selector::alu_function op_f_s;
    logic [N-1:0]         alu_y_s;
    logic                 alu_err_s;

    // Leading-zero count from the MSB; an all-zero input yields N.
    function automatic logic [CW-1:0] count_lz(input logic [N-1:0] v);
        logic [CW-1:0] cnt_v;
        logic          stop_v;
        cnt_v  = '0;
        stop_v = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!stop_v && !v[i]) begin
                cnt_v = cnt_v + CW'(1);
            end else begin
                stop_v = 1'b1;
            end
        end
        return cnt_v;
    endfunction

    // Round-robin scan: first valid requester at rr_ptr, rr_ptr+1, ... mod REQ.
    always_comb begin
        logic [IW:0] idx_v;
        gnt_any_s = 1'b0;
        gnt_id_s  = '0;
        idx_v     = '0;
        for (int k = 0; k < REQ; k++) begin
            idx_v = {1'b0, rr_ptr_r} + IW1'(k);
            if (idx_v >= IW1'(REQ)) begin
                idx_v = idx_v - IW1'(REQ);
            end else begin
                idx_v = idx_v;
            end
            if (!gnt_any_s && req_valid[idx_v[IW-1:0]]) begin
                gnt_any_s = 1'b1;
                gnt_id_s  = idx_v[IW-1:0];
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // A held result that is not being drained blocks new work; reset blocks all.
    assign can_accept_s = !rsp_valid || rsp_ready;
    assign accept_s     = gnt_any_s && can_accept_s && rst_n;

    // One-hot ready toward the granted requester only.
    always_comb begin
        req_ready = '0;
        if (accept_s) begin
            req_ready[gnt_id_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Pointer moves to the requester after the one just accepted.
    always_comb begin
        logic [IW:0] nxt_v;
        nxt_v = {1'b0, gnt_id_s} + IW1'(1);
        if (nxt_v >= IW1'(REQ)) begin
            rr_nxt_s = '0;
        end else begin
            rr_nxt_s = nxt_v[IW-1:0];
        end
    end

    assign op_a_s  = req_a[gnt_id_s];
    assign op_b_s  = req_b[gnt_id_s];
    assign op_sa_s = req_sa[gnt_id_s];
    assign op_f_s  = req_funct[gnt_id_s];

    // Shared logic unit; shifts and rotate act on b, counts act on a.
    always_comb begin
        alu_y_s   = '0;
        alu_err_s = 1'b0;
        case (op_f_s)
            selector::AND:                    alu_y_s = op_a_s & op_b_s;
            selector::OR:                     alu_y_s = op_a_s | op_b_s;
            selector::XOR:                    alu_y_s = op_a_s ^ op_b_s;
            selector::NOR:                    alu_y_s = ~(op_a_s | op_b_s);
            selector::SHIFT_LEFT:             alu_y_s = op_b_s << op_sa_s;
            selector::SHIFT_LOGIC_RIGHT:      alu_y_s = op_b_s >> op_sa_s;
            selector::SHIFT_ARITHMATIC_RIGHT: alu_y_s = $signed(op_b_s) >>> op_sa_s;
            // Doubling b makes the low half of the right shift a rotate, sa=0 included.
            selector::ROTATE_RIGHT:           alu_y_s = N'({op_b_s, op_b_s} >> op_sa_s);
            selector::CLZ:                    alu_y_s = N'(count_lz(op_a_s));
            selector::CLO:                    alu_y_s = N'(count_lz(~op_a_s));
            default: begin
                alu_y_s   = '0;
                alu_err_s = 1'b1;
            end
        endcase
    end

    // Result stage and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_err   <= 1'b0;
            rr_ptr_r  <= '0;
        end else if (accept_s) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id_s;
            rsp_y     <= alu_y_s;
            rsp_err   <= alu_err_s;
            rr_ptr_r  <= rr_nxt_s;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;   // drained, payload left as is
        end
    end

endmodule

// File: tb/tb_alu_logic_arbiter.sv
module tb_alu_logic_arbiter;

    logic                  clk;
    logic                  rst_n;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [31:0]           req_a     [2];
    logic [31:0]           req_b     [2];
    selector::alu_function req_funct [2];
    logic [4:0]            req_sa    [2];
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [0:0]            rsp_id;
    logic [31:0]           rsp_y;
    logic                  rsp_err;

    int n_vec = 0;
    int n_err = 0;

    alu_logic_arbiter #(.N(32), .REQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_funct (req_funct),
        .req_sa    (req_sa),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] id, input logic [31:0] y,
                           input logic [31:0] err);
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".id"},    32'(rsp_id),    id);
        chk({tag, ".y"},     rsp_y,          y);
        chk({tag, ".err"},   32'(rsp_err),   err);
    endtask

    task automatic set_req(input int i, input selector::alu_function f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sa);
        req_funct[i] = f;
        req_a[i]     = a;
        req_b[i]     = b;
        req_sa[i]    = sa;
    endtask

    // Present one op on requester 0 only, then check the response one cycle later.
    task automatic step_req0(input string tag, input selector::alu_function f,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa,
                             input logic [31:0] y, input logic [31:0] err);
        set_req(0, f, a, b, sa);
        @(posedge clk);
        @(negedge clk);
        chk_rsp(tag, 32'd0, y, err);
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        set_req(0, selector::AND, 32'hF0F0_0000, 32'h0FF0_00FF, 5'd0);
        set_req(1, selector::OR,  32'h0000_0001, 32'h0000_0002, 5'd0);

        // Reset held with every requester valid
        repeat (3) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_y",     rsp_y,          32'd0);
        chk("rst.rsp_id",    32'(rsp_id),    32'd0);
        chk("rst.rsp_err",   32'(rsp_err),   32'd0);

        rst_n = 1'b1;
        #1;
        chk("rel.req_ready", 32'(req_ready), 32'b01);

        // Round robin, back to back: 0 (AND), 1 (OR), 0 (XOR), 1 (NOR)
        @(posedge clk);
        @(negedge clk);
        chk_rsp("rr0_and", 32'd0, 32'h00F0_0000, 32'd0);
        chk("rr0.req_ready", 32'(req_ready), 32'b10);
        set_req(0, selector::XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0);
        @(posedge clk);
        @(negedge clk);
        chk_rsp("rr1_or", 32'd1, 32'h0000_0003, 32'd0);
        set_req(1, selector::NOR, 32'h0000_0000, 32'h0000_0000, 5'd0);
        @(posedge clk);
        @(negedge clk);
        chk_rsp("rr2_xor", 32'd0, 32'hF0F0_0F0F, 32'd0);
        set_req(0, selector::SHIFT_LEFT, 32'h0, 32'h0000_0001, 5'd4);
        @(posedge clk);
        @(negedge clk);
        chk_rsp("rr3_nor", 32'd1, 32'hFFFF_FFFF, 32'd0);

        // Backpressure: result held, no requester accepted
        rsp_ready = 1'b0;
        set_req(1, selector::ROTATE_RIGHT, 32'h0, 32'h0000_0001, 5'd1);
        #1;
        chk("bp.req_ready", 32'(req_ready), 32'b00);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk_rsp("bp_hold", 32'd1, 32'hFFFF_FFFF, 32'd0);
            chk("bp.req_ready", 32'(req_ready), 32'b00);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release.req_ready", 32'(req_ready), 32'b01);
        @(posedge clk);
        @(negedge clk);
        chk_rsp("sll", 32'd0, 32'h0000_0010, 32'd0);

        // Requester 1's pending rotate is next in round-robin order
        set_req(0, selector::SHIFT_ARITHMATIC_RIGHT, 32'h0, 32'h8000_0000, 5'd31);
        @(posedge clk);
        @(negedge clk);
        chk_rsp("ror1", 32'd1, 32'h8000_0000, 32'd0);
        req_valid = 2'b01;

        // Edge functions on requester 0 alone
        step_req0("sar31",   selector::SHIFT_ARITHMATIC_RIGHT, 32'h0, 32'h8000_0000, 5'd31,
                  32'hFFFF_FFFF, 32'd0);
        step_req0("srl31",   selector::SHIFT_LOGIC_RIGHT, 32'h0, 32'h8000_0000, 5'd31,
                  32'h0000_0001, 32'd0);
        step_req0("ror0",    selector::ROTATE_RIGHT, 32'h0, 32'h1234_5678, 5'd0,
                  32'h1234_5678, 32'd0);
        step_req0("clz15",   selector::CLZ, 32'h0001_0000, 32'h0, 5'd0, 32'd15, 32'd0);
        step_req0("clz0",    selector::CLZ, 32'h0000_0000, 32'h0, 5'd0, 32'd32, 32'd0);
        step_req0("clo32",   selector::CLO, 32'hFFFF_FFFF, 32'h0, 5'd0, 32'd32, 32'd0);
        step_req0("clo4",    selector::CLO, 32'hF0FF_FFFF, 32'h0, 5'd0, 32'd4,  32'd0);
        step_req0("illegal", selector::ADD, 32'h0000_0001, 32'h0000_0001, 5'd0,
                  32'h0000_0000, 32'd1);

        // Stall with the error result, then an asynchronous reset pulse mid-stall
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_rsp("err_hold", 32'd0, 32'h0000_0000, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst.req_ready", 32'(req_ready), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("post_rst.req_ready", 32'(req_ready), 32'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
